s510_timing_counters: RTL
=========================

S510_TIMING_COUNTERS -- requirements
Module: s510_timing_counters

Interface
REQ-001 Parameter CNT_W, default 10: main counter width in bits; SHALL be at least 10.
REQ-002 Parameter PCNT_W, default 8: pixel counter width in bits; SHALL be at least 8.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 cnt_en  input  1  main counter increment enable.
REQ-006 cclr_pad  input  1  main counter clear, from the s510 state/decode stage.
REQ-007 pc_pad  input  1  pixel counter increment request, from the s510 stage.
REQ-008 pclr_pad  input  1  pixel counter clear, from the s510 stage.
REQ-009 cnt10_pad, cnt13_pad, cnt21_pad, cnt44_pad, cnt45_pad, cnt261_pad, cnt272_pad, cnt283_pad, cnt284_pad, cnt509_pad, cnt511_pad, cnt567_pad, cnt591_pad  output  1 each  main counter equals N, where N is the number in the port name.
REQ-010 pcnt6_pad, pcnt12_pad, pcnt17_pad, pcnt27_pad, pcnt241_pad  output  1 each  pixel counter equals N.
REQ-011 cnt_val  output  CNT_W  current main count; pcnt_val  output  PCNT_W  current pixel count.
REQ-012 cnt_ovf, pcnt_ovf  output  1 each  sticky overflow status; present only with S510_TC_OVF_STATUS_EN.

Function
REQ-013 Main counter update priority, per rising edge: rst, then cclr_pad, then cnt_en, then hold.
- cclr_pad=1: counter becomes 0, regardless of cnt_en.
- cclr_pad=0 and cnt_en=1: counter increments by 1.
- otherwise: counter holds.
REQ-014 Pixel counter update priority, per rising edge: rst, then pclr_pad, then pc_pad, then hold; same rules as REQ-013.
REQ-015 Each cntN_pad and pcntN_pad output SHALL be a purely combinational equality decode of the corresponding counter register.
- Zero-cycle latency from the register value.
- No glitch-dependent behaviour.
- Exactly one flag of a counter asserted when its value equals a listed N; none asserted otherwise.
REQ-016 A clear or increment applied in cycle k SHALL be reflected in the counter value and flags from cycle k+1.
REQ-017 Wrap-around without the macro: counter at 2^W-1 with increment SHALL become 0; no other side effect.
REQ-018 cnt_val and pcnt_val SHALL equal the counter registers directly.
REQ-019 The two counters SHALL be fully independent; simultaneous activity on both SHALL NOT interact.
REQ-020 The block SHALL contain no other state, and all outputs SHALL be Moore functions of the registers.

Reset
REQ-021 rst=1 at a rising edge SHALL set both counters to 0, overriding every other input.
REQ-022 Reset values of all outputs:
- cnt_val = 0, pcnt_val = 0.
- All cntN_pad and pcntN_pad = 0.
- cnt_ovf = 0, pcnt_ovf = 0 (when present).
REQ-023 rst asserted mid-count SHALL take effect at the next edge, and counting SHALL resume from 0 on the first edge after rst deasserts.

Configuration
REQ-024 Macro S510_TC_OVF_STATUS_EN defined:
- A counter at 2^W-1 receiving an increment SHALL saturate at 2^W-1 and set its ovf flag.
- The ovf flag SHALL stay set until the corresponding clear input or rst.
- A clear and an overflowing increment in the same cycle: clear wins, and ovf SHALL end 0.
REQ-025 Macro S510_TC_OVF_STATUS_EN undefined:
- cnt_ovf and pcnt_ovf ports and their logic SHALL be absent.
- Counters SHALL wrap per REQ-017.

Verification
REQ-026 rst=1 for 2 cycles with cnt_en=1, pc_pad=1 -> cnt_val=0, pcnt_val=0, all flags 0 throughout.
REQ-027 cnt_en=1 for 591 cycles after reset -> cnt10_pad high only when cnt_val=10, ..., cnt591_pad high on cycle 591, each for exactly one cycle; cnt511_pad and cnt509_pad each seen exactly once.
REQ-028 Counter at 283, cclr_pad=1 and cnt_en=1 in the same cycle -> next cycle cnt_val=0, cnt283_pad=0, cnt284_pad never asserted.
REQ-029 pc_pad pulsed 241 times with gaps of 0-3 idle cycles -> pcnt6/12/17/27/241_pad each asserted while pcnt_val holds the value, including across idle gaps; pclr_pad together with pc_pad -> pcnt_val=0.
REQ-030 Without macro: pcnt_val=255 plus pc_pad -> pcnt_val=0. With macro: pcnt_val=255 plus pc_pad -> pcnt_val stays 255 and pcnt_ovf=1 until pclr_pad, then pcnt_ovf=0 and pcnt_val=0.
REQ-031 rst pulsed while cnt_val=400 -> cnt_val=0 the next cycle and counting resumes, cnt10_pad asserted 10 cycles after rst deasserts.

Source files
------------

// File: rtl/s510_timing_counters.sv
// Main and pixel timing counters with combinational equality decodes for the s510 sequencer.
// Optional S510_TC_OVF_STATUS_EN: saturate at all-ones and expose sticky cnt_ovf/pcnt_ovf.
module s510_timing_counters #(
    parameter int unsigned CNT_W  = 10,
    parameter int unsigned PCNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cnt_en,
    input  logic              cclr_pad,
    input  logic              pc_pad,
    input  logic              pclr_pad,
    output logic              cnt10_pad,
    output logic              cnt13_pad,
    output logic              cnt21_pad,
    output logic              cnt44_pad,
    output logic              cnt45_pad,
    output logic              cnt261_pad,
    output logic              cnt272_pad,
    output logic              cnt283_pad,
    output logic              cnt284_pad,
    output logic              cnt509_pad,
    output logic              cnt511_pad,
    output logic              cnt567_pad,
    output logic              cnt591_pad,
    output logic              pcnt6_pad,
    output logic              pcnt12_pad,
    output logic              pcnt17_pad,
    output logic              pcnt27_pad,
    output logic              pcnt241_pad,
    output logic [CNT_W-1:0]  cnt_val,
    output logic [PCNT_W-1:0] pcnt_val
`ifdef S510_TC_OVF_STATUS_EN
    ,
    output logic              cnt_ovf,
    output logic              pcnt_ovf
`endif
);

    logic [CNT_W-1:0]  cnt_q,  cnt_d;
    logic [PCNT_W-1:0] pcnt_q, pcnt_d;

`ifdef S510_TC_OVF_STATUS_EN
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [PCNT_W-1:0] PCNT_MAX = '1;

    logic cnt_ovf_q,  cnt_ovf_d;
    logic pcnt_ovf_q, pcnt_ovf_d;
`endif

    // Next-state: clear beats increment beats hold, independently per counter.
    always_comb begin
        cnt_d  = cnt_q;
        pcnt_d = pcnt_q;
`ifdef S510_TC_OVF_STATUS_EN
        cnt_ovf_d  = cnt_ovf_q;
        pcnt_ovf_d = pcnt_ovf_q;
`endif
        if (cclr_pad) begin
            cnt_d = '0;
`ifdef S510_TC_OVF_STATUS_EN
            cnt_ovf_d = 1'b0;
`endif
        end else if (cnt_en) begin
`ifdef S510_TC_OVF_STATUS_EN
            if (cnt_q == CNT_MAX) cnt_ovf_d = 1'b1;
            else                  cnt_d     = cnt_q + CNT_W'(1);
`else
            cnt_d = cnt_q + CNT_W'(1);
`endif
        end

        if (pclr_pad) begin
            pcnt_d = '0;
`ifdef S510_TC_OVF_STATUS_EN
            pcnt_ovf_d = 1'b0;
`endif
        end else if (pc_pad) begin
`ifdef S510_TC_OVF_STATUS_EN
            if (pcnt_q == PCNT_MAX) pcnt_ovf_d = 1'b1;
            else                    pcnt_d     = pcnt_q + PCNT_W'(1);
`else
            pcnt_d = pcnt_q + PCNT_W'(1);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            pcnt_q <= '0;
`ifdef S510_TC_OVF_STATUS_EN
            cnt_ovf_q  <= 1'b0;
            pcnt_ovf_q <= 1'b0;
`endif
        end else begin
            cnt_q  <= cnt_d;
            pcnt_q <= pcnt_d;
`ifdef S510_TC_OVF_STATUS_EN
            cnt_ovf_q  <= cnt_ovf_d;
            pcnt_ovf_q <= pcnt_ovf_d;
`endif
        end
    end

    assign cnt_val  = cnt_q;
    assign pcnt_val = pcnt_q;
`ifdef S510_TC_OVF_STATUS_EN
    assign cnt_ovf  = cnt_ovf_q;
    assign pcnt_ovf = pcnt_ovf_q;
`endif

    // Equality decodes straight off the registers.
    assign cnt10_pad  = (cnt_q == CNT_W'(10));
    assign cnt13_pad  = (cnt_q == CNT_W'(13));
    assign cnt21_pad  = (cnt_q == CNT_W'(21));
    assign cnt44_pad  = (cnt_q == CNT_W'(44));
    assign cnt45_pad  = (cnt_q == CNT_W'(45));
    assign cnt261_pad = (cnt_q == CNT_W'(261));
    assign cnt272_pad = (cnt_q == CNT_W'(272));
    assign cnt283_pad = (cnt_q == CNT_W'(283));
    assign cnt284_pad = (cnt_q == CNT_W'(284));
    assign cnt509_pad = (cnt_q == CNT_W'(509));
    assign cnt511_pad = (cnt_q == CNT_W'(511));
    assign cnt567_pad = (cnt_q == CNT_W'(567));
    assign cnt591_pad = (cnt_q == CNT_W'(591));

    assign pcnt6_pad   = (pcnt_q == PCNT_W'(6));
    assign pcnt12_pad  = (pcnt_q == PCNT_W'(12));
    assign pcnt17_pad  = (pcnt_q == PCNT_W'(17));
    assign pcnt27_pad  = (pcnt_q == PCNT_W'(27));
    assign pcnt241_pad = (pcnt_q == PCNT_W'(241));

endmodule
